// File: rtl/usb_ep_loopback_bridge_if.sv
// usb_ep_loopback_bridge_if: endpoint-side bundle for the loopback bridge.
// master = bridge side, slave = usb1_top / board side.
interface usb_ep_loopback_bridge_if;
  logic        loop_en;
  logic [7:0]  ep2_dout;
  logic        ep2_re;
  logic [3:0]  ep2_stat;
  logic [7:0]  ep1_din;
  logic        ep1_we;
  logic [3:0]  ep1_stat;
  logic [7:0]  led;
  logic [15:0] byte_cnt;
  logic        busy;

  modport master (
    input  loop_en,
    input  ep2_dout,
    input  ep2_stat,
    input  ep1_stat,
    output ep2_re,
    output ep1_din,
    output ep1_we,
    output led,
    output byte_cnt,
    output busy
  );

  modport slave (
    output loop_en,
    output ep2_dout,
    output ep2_stat,
    output ep1_stat,
    input  ep2_re,
    input  ep1_din,
    input  ep1_we,
    input  led,
    input  byte_cnt,
    input  busy
  );
endinterface

// File: rtl/usb_ep_loopback_bridge.sv
// usb_ep_loopback_bridge: drains ep2 OUT bytes into a small FIFO,
// XORs them with a key and echoes them to ep1 IN.
module usb_ep_loopback_bridge #(
  parameter int          DEPTH   = 4,
  parameter int          AW      = 2,
  parameter logic [7:0]  XOR_KEY = 8'h00
) (
  input logic clk_i,
  input logic rst_i,
  usb_ep_loopback_bridge_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fill_q;
  logic [7:0]    din_q;
  logic          we_q;
  logic [7:0]    led_q;
  logic [15:0]   byte_cnt_q;

  logic          ep2_empty;
  logic          ep1_full;
  logic          inflight;
  logic [AW+1:0] need;
  logic          room;
  logic          push;
  logic          pop;
  logic          unused_stat;

  assign ep2_empty = bus.ep2_stat[1];
  assign ep1_full  = bus.ep1_stat[0];

  assign unused_stat = ^{bus.ep2_stat[3:2], bus.ep2_stat[0],
                         bus.ep1_stat[3:1]};

  // A read in flight already owns a FIFO slot.
  assign inflight = (state_q != S_IDLE);
  assign need     = {1'b0, fill_q} + {{(AW+1){1'b0}}, inflight};
  assign room     = (need < DEPTH_W);

  assign push = (state_q == S_CAP);
  assign pop  = !we_q && (fill_q != '0) && !ep1_full;

  // Read FSM next state: IDLE -> REQ -> CAP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.loop_en && !ep2_empty && room) begin
          state_d = S_REQ;
        end
      end
      S_REQ:   state_d = S_CAP;
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage; the key is applied on the way in.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.ep2_dout ^ XOR_KEY;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // ep1 write side: one strobe at most every other cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q  <= 1'b0;
      din_q <= 8'h00;
    end else begin
      we_q <= pop;
      if (pop) begin
        din_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // LED mirror and byte counter follow each ep1 write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q      <= 8'h00;
      byte_cnt_q <= 16'h0000;
    end else if (we_q) begin
      led_q      <= din_q;
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign bus.ep2_re   = (state_q == S_REQ);
  assign bus.ep1_we   = we_q;
  assign bus.ep1_din  = din_q;
  assign bus.led      = led_q;
  assign bus.byte_cnt = byte_cnt_q;
  assign bus.busy     = (fill_q != '0) | inflight | we_q;

endmodule

// File: tb/tb_usb_ep_loopback_bridge.sv
// tb_usb_ep_loopback_bridge: randomized scoreboard bench with an
// ep2 source model; two instances cover key 00 and key A5.
module tb_usb_ep_loopback_bridge;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic loop_en = 1'b0;
  logic ep1_full = 1'b0;
  logic [7:0] ep2_dout;
  logic ep2_empty;

  always #5 clk_i = ~clk_i;

  usb_ep_loopback_bridge_if ifa();
  usb_ep_loopback_bridge_if ifb();

  assign ifa.loop_en  = loop_en;
  assign ifa.ep2_dout = ep2_dout;
  assign ifa.ep2_stat = {2'b00, ep2_empty, 1'b0};
  assign ifa.ep1_stat = {3'b000, ep1_full};
  assign ifb.loop_en  = loop_en;
  assign ifb.ep2_dout = ep2_dout;
  assign ifb.ep2_stat = {2'b00, ep2_empty, 1'b0};
  assign ifb.ep1_stat = {3'b000, ep1_full};

  usb_ep_loopback_bridge #(
    .DEPTH(4), .AW(2), .XOR_KEY(8'h00)
  ) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(ifa.master)
  );

  usb_ep_loopback_bridge #(
    .DEPTH(4), .AW(2), .XOR_KEY(8'hA5)
  ) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(ifb.master)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] m_led0 = 8'h00;
  logic [7:0] m_led1 = 8'h00;
  logic [15:0] m_cnt0 = 16'h0000;
  logic [15:0] m_cnt1 = 16'h0000;
  logic prev_we0 = 1'b0;
  logic prev_we1 = 1'b0;
  int re_cnt = 0;
  int cyc = 0;
  int last_re = -10;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    exp0.push_back(b);
    exp1.push_back(b ^ 8'hA5);
  endtask

  // ep2 FIFO model: data one cycle after the strobe, empty flag
  // reflects the queue after the last read.
  always @(posedge clk_i) begin
    cyc++;
    if (ifa.ep2_re) begin
      re_cnt++;
      chk("ep2_re spacing>=3", 32'(cyc - last_re >= 3), 32'd1);
      last_re = cyc;
      n_chk++;
      if (src_q.size() == 0) begin
        n_err++;
        $display("FAIL ep2 read while empty: got ep2_re=1 required 0");
        ep2_dout <= 8'hEE;
      end else begin
        ep2_dout <= src_q.pop_front();
      end
    end
    ep2_empty <= (src_q.size() == 0);
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    logic [7:0] e;
    if (ifa.ep1_we) begin
      chk("dut0 ep1_we adjacent", 32'(prev_we0), 32'd0);
      n_chk++;
      if (exp0.size() == 0) begin
        n_err++;
        $display("FAIL dut0 spurious ep1_we: got din=%h required none",
                 ifa.ep1_din);
      end else begin
        e = exp0.pop_front();
        chk("dut0 ep1_din", 32'(ifa.ep1_din), 32'(e));
        chk("dut0 led", 32'(ifa.led), 32'(m_led0));
        chk("dut0 byte_cnt", 32'(ifa.byte_cnt), 32'(m_cnt0));
        m_led0 = e;
        m_cnt0 = m_cnt0 + 16'd1;
      end
    end
    prev_we0 = ifa.ep1_we;
    if (ifb.ep1_we) begin
      chk("dut1 ep1_we adjacent", 32'(prev_we1), 32'd0);
      n_chk++;
      if (exp1.size() == 0) begin
        n_err++;
        $display("FAIL dut1 spurious ep1_we: got din=%h required none",
                 ifb.ep1_din);
      end else begin
        e = exp1.pop_front();
        chk("dut1 ep1_din", 32'(ifb.ep1_din), 32'(e));
        chk("dut1 led", 32'(ifb.led), 32'(m_led1));
        chk("dut1 byte_cnt", 32'(ifb.byte_cnt), 32'(m_cnt1));
        m_led1 = e;
        m_cnt1 = m_cnt1 + 16'd1;
      end
    end
    prev_we1 = ifb.ep1_we;
  end

  task automatic drain(input string nm, input int budget);
    int t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || src_q.size() != 0 ||
            ifa.busy || ifb.busy) && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    chk({nm, " drain in budget"}, 32'(t < budget), 32'd1);
  endtask

  task automatic wait_re(input string nm);
    int t = 0;
    while (!ifa.ep2_re && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    chk({nm, " ep2_re seen"}, 32'(ifa.ep2_re), 32'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " dut0 ep2_re"}, 32'(ifa.ep2_re), 32'd0);
    chk({nm, " dut0 ep1_we"}, 32'(ifa.ep1_we), 32'd0);
    chk({nm, " dut0 ep1_din"}, 32'(ifa.ep1_din), 32'd0);
    chk({nm, " dut0 led"}, 32'(ifa.led), 32'd0);
    chk({nm, " dut0 byte_cnt"}, 32'(ifa.byte_cnt), 32'd0);
    chk({nm, " dut0 busy"}, 32'(ifa.busy), 32'd0);
    chk({nm, " dut1 ep1_din"}, 32'(ifb.ep1_din), 32'd0);
    chk({nm, " dut1 byte_cnt"}, 32'(ifb.byte_cnt), 32'd0);
    chk({nm, " dut1 busy"}, 32'(ifb.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int re0;
    int pushed;
    repeat (3) @(negedge clk_i);
    chk_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Pure echo of three bytes.
    loop_en = 1'b1;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    drain("echo", 200);
    chk("echo dut0 led", 32'(ifa.led), 32'h03);
    chk("echo dut0 byte_cnt", 32'(ifa.byte_cnt), 32'd3);
    chk("echo dut1 led", 32'(ifb.led), 32'hA6);

    // Keyed byte.
    push_byte(8'h5A);
    drain("xor", 100);
    chk("xor dut1 led", 32'(ifb.led), 32'hFF);
    chk("xor dut0 led", 32'(ifa.led), 32'h5A);

    // ep1 held full: only DEPTH reads may start.
    ep1_full = 1'b1;
    @(negedge clk_i);
    re0 = re_cnt;
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    repeat (60) @(negedge clk_i);
    chk("full ep2_re count", 32'(re_cnt - re0), 32'd4);
    chk("full no write", 32'(exp0.size()), 32'd10);
    ep1_full = 1'b0;
    drain("full", 400);

    // loop_en dropped while the read is in REQ.
    loop_en = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    repeat (3) @(negedge clk_i);
    re0 = re_cnt;
    loop_en = 1'b1;
    @(negedge clk_i);
    wait_re("stop");
    loop_en = 1'b0;
    repeat (30) @(negedge clk_i);
    chk("stop ep2_re count", 32'(re_cnt - re0), 32'd1);
    chk("stop delivered", 32'(exp0.size()), 32'd2);
    chk("stop dut0 busy", 32'(ifa.busy), 32'd0);
    chk("stop dut0 led", 32'(ifa.led), 32'h11);
    loop_en = 1'b1;
    drain("stop", 200);

    // Randomized traffic with back-pressure and loop_en toggling.
    pushed = 0;
    while (pushed < 80) begin
      @(negedge clk_i);
      if ($urandom_range(0, 2) == 0) begin
        push_byte(8'($urandom));
        pushed++;
      end
      ep1_full = ($urandom_range(0, 3) == 0);
      loop_en  = ($urandom_range(0, 7) != 0);
    end
    ep1_full = 1'b0;
    loop_en  = 1'b1;
    drain("random", 3000);
    chk("random dut0 byte_cnt", 32'(ifa.byte_cnt), 32'(m_cnt0));
    chk("random dut1 led", 32'(ifb.led), 32'(m_led1));

    // Counter wrap from a forced FFFF.
    @(negedge clk_i);
    force dut0.byte_cnt_q = 16'hFFFF;
    @(negedge clk_i);
    release dut0.byte_cnt_q;
    m_cnt0 = 16'hFFFF;
    push_byte(8'h7E);
    drain("wrap", 100);
    chk("wrap dut0 byte_cnt", 32'(ifa.byte_cnt), 32'h0000);

    // Reset while a read is in CAP: the byte is lost.
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    @(negedge clk_i);
    wait_re("rst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    src_q.delete();
    exp0.delete();
    exp1.delete();
    m_led0 = 8'h00;
    m_led1 = 8'h00;
    m_cnt0 = 16'h0000;
    m_cnt1 = 16'h0000;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (30) @(negedge clk_i);
    chk("midrst dut0 byte_cnt", 32'(ifa.byte_cnt), 32'd0);
    chk("midrst dut0 busy", 32'(ifa.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
